// File: rtl/scan_config_loader.sv
// rtl/scan_config_loader.sv - serialises config words into a tile's CLB and connection scan chains
//
// Words accepted on a valid/ready stream are shifted out LSB-first: the first
// CLB_CHAIN_LEN bits go to the CLB chain, the next CONN_CHAIN_LEN bits go to the
// connection chain. One scan shift per i_scan_clk cycle. Bits of the final word
// that fall past the end of the connection chain are discarded.
//
// Optional feature macro: SCAN_LOADER_READBACK_EN (chain scan_out capture).
//
// Ports:
//   i_scan_clk        sole clock, rising edge
//   i_rst             synchronous active-high reset
//   i_start           one-cycle pulse, begins a load when idle
//   i_in_data         bitstream word, bit 0 shifted first
//   i_in_valid        i_in_data valid
//   o_in_ready        word accepted when i_in_valid && o_in_ready
//   o_clb_scan_data   serial data to CLB chain scan_in
//   o_clb_scan_en     CLB chain shift enable
//   o_conn_scan_data  serial data to connection chain scan_in
//   o_conn_scan_en    connection chain shift enable
//   o_busy            high from start accept until DONE exit
//   o_done            one-cycle pulse after the final bit is shifted
//   i_clb_scan_ret    (readback) CLB chain scan_out
//   i_conn_scan_ret   (readback) connection chain scan_out
//   o_rb_data         (readback) packed captured word, LSB first
//   o_rb_valid        (readback) o_rb_data valid pulse

module scan_config_loader #(
  parameter int WORD_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 10,
  parameter int CONN_CHAIN_LEN = 6
) (
  input  logic                  i_scan_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_clb_scan_data,
  output logic                  o_clb_scan_en,
  output logic                  o_conn_scan_data,
  output logic                  o_conn_scan_en,
  output logic                  o_busy,
  output logic                  o_done
`ifdef SCAN_LOADER_READBACK_EN
  ,
  input  logic                  i_clb_scan_ret,
  input  logic                  i_conn_scan_ret,
  output logic [WORD_WIDTH-1:0] o_rb_data,
  output logic                  o_rb_valid
`endif
);

  localparam int TOTAL = CLB_CHAIN_LEN + CONN_CHAIN_LEN;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int HW    = $clog2(WORD_WIDTH + 1);

  localparam logic [BW-1:0] C_TOTAL = BW'(TOTAL);
  localparam logic [BW-1:0] C_LAST  = BW'(TOTAL - 1);
  localparam logic [BW-1:0] C_CLB   = BW'(CLB_CHAIN_LEN);
  localparam logic [HW-1:0] C_WORD  = HW'(WORD_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_hold;
  logic [HW-1:0]         r_hcnt;    // unshifted bits left in r_hold
  logic [BW-1:0]         r_bitcnt;  // bits shifted so far this load

  logic          w_accept;
  logic          w_emit;
  logic          w_last;
  logic          w_to_clb;
  logic          w_load_nxt;
  logic          w_ready_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  logic [BW-1:0] w_bitcnt_nxt;

  assign w_accept     = o_in_ready && i_in_valid;
  assign w_emit       = (r_state == S_LOAD) && (r_hcnt != '0);
  assign w_last       = w_emit && (r_bitcnt == C_LAST);
  assign w_to_clb     = (r_bitcnt < C_CLB);
  assign w_bitcnt_nxt = w_emit ? (r_bitcnt + BW'(1)) : r_bitcnt;

  // A new word can land in the same edge that shifts out the last held bit,
  // which is what keeps back-to-back words gap-free.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (w_last) begin
      w_hcnt_nxt = '0;
    end else if (w_accept) begin
      w_hcnt_nxt = C_WORD;
    end else if (w_emit) begin
      w_hcnt_nxt = r_hcnt - HW'(1);
    end
  end

  // o_in_ready is registered, so it is computed from next-cycle state.
  assign w_load_nxt  = ((r_state == S_IDLE) && i_start) ||
                       ((r_state == S_LOAD) && (r_bitcnt != C_TOTAL));
  assign w_ready_nxt = w_load_nxt && (w_bitcnt_nxt != C_TOTAL) &&
                       ((w_hcnt_nxt == '0) ||
                        ((w_hcnt_nxt == HW'(1)) && (w_bitcnt_nxt != C_LAST)));

  always_ff @(posedge i_scan_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_hold           <= '0;
      r_hcnt           <= '0;
      r_bitcnt         <= '0;
      o_in_ready       <= 1'b0;
      o_clb_scan_data  <= 1'b0;
      o_clb_scan_en    <= 1'b0;
      o_conn_scan_data <= 1'b0;
      o_conn_scan_en   <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      o_in_ready <= w_ready_nxt;
      case (r_state)
        S_IDLE: begin
          o_clb_scan_data  <= 1'b0;
          o_clb_scan_en    <= 1'b0;
          o_conn_scan_data <= 1'b0;
          o_conn_scan_en   <= 1'b0;
          o_done           <= 1'b0;
          if (i_start) begin
            r_state  <= S_LOAD;
            r_hold   <= '0;
            r_hcnt   <= '0;
            r_bitcnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          o_clb_scan_en    <= w_emit && w_to_clb;
          o_clb_scan_data  <= w_emit && w_to_clb && r_hold[0];
          o_conn_scan_en   <= w_emit && !w_to_clb;
          o_conn_scan_data <= w_emit && !w_to_clb && r_hold[0];
          r_hcnt           <= w_hcnt_nxt;
          r_bitcnt         <= w_bitcnt_nxt;
          if (w_last) begin
            r_hold <= '0;
          end else if (w_accept) begin
            r_hold <= i_in_data;
          end else if (w_emit) begin
            r_hold <= r_hold >> 1;
          end
          // Final bit is on the outputs this cycle; it shifts at this edge.
          if (r_bitcnt == C_TOTAL) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state          <= S_IDLE;
          r_bitcnt         <= '0;
          o_clb_scan_data  <= 1'b0;
          o_clb_scan_en    <= 1'b0;
          o_conn_scan_data <= 1'b0;
          o_conn_scan_en   <= 1'b0;
          o_done           <= 1'b0;
          o_busy           <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_LOADER_READBACK_EN
  localparam int RW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] r_rb_sr;
  logic [RW-1:0]         r_rb_cnt;
  logic                  w_rb_shift;
  logic                  w_rb_bit;
  logic                  w_rb_final;

  // The chain shifts at the edge ending a cycle whose scan_en is high, so the
  // bit leaving scan_out is captured at that same edge.
  assign w_rb_shift = o_clb_scan_en || o_conn_scan_en;
  assign w_rb_bit   = o_clb_scan_en ? i_clb_scan_ret : i_conn_scan_ret;
  assign w_rb_final = (r_state == S_LOAD) && (r_bitcnt == C_TOTAL);

  always_ff @(posedge i_scan_clk) begin
    if (i_rst) begin
      r_rb_sr    <= '0;
      r_rb_cnt   <= '0;
      o_rb_data  <= '0;
      o_rb_valid <= 1'b0;
    end else begin
      o_rb_valid <= 1'b0;
      if (w_rb_shift) begin
        if ((r_rb_cnt == RW'(WORD_WIDTH - 1)) || w_rb_final) begin
          // Unfilled upper bits of r_rb_sr are still zero, giving the padding.
          o_rb_data  <= r_rb_sr | (WORD_WIDTH'(w_rb_bit) << r_rb_cnt);
          o_rb_valid <= 1'b1;
          r_rb_sr    <= '0;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_sr[r_rb_cnt] <= w_rb_bit;
          r_rb_cnt          <= r_rb_cnt + RW'(1);
        end
      end
    end
  end
`endif

endmodule
